imem_loadable: RTL and testbench

Parametrised instruction memory that supersedes the fixed 64x32 combinational ROM. Program contents arrive at run time over a byte-serial load port. Instruction fetch uses a valid/ready handshake with a registered one-cycle read, and reports misaligned or out-of-range PC faults. The block sits between the program loader (UART/testbench) and the single-cycle core's fetch stage.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_byte_packer.sv | 37 +++
 rtl/imem_loadable.sv | 133 +++++++++++++
 tb/tb_imem_loadable.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the run-time loadable instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles little-endian load bytes into 32-bit words; a flush emits any
// partial word with its unfilled upper lanes zero.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        data_valid,
  input  logic [7:0]  data,
  input  logic        flush,
  output logic [31:0] word,
  output logic        word_we
);

  logic [1:0] cnt;
  logic [7:0] lane   [4];
  logic [7:0] lane_n [4];

  // Lanes are zeroed whenever a word leaves, so padding comes for free.
  always_comb begin
    for (int i = 0; i < 4; i++) lane_n[i] = lane[i];
    if (data_valid) lane_n[cnt] = data;
    word    = {lane_n[3], lane_n[2], lane_n[1], lane_n[0]};
    word_we = (data_valid && (cnt == 2'd3)) ||
              (flush && (data_valid || (cnt != 2'd0)));
  end

  always_ff @(posedge clk) begin
    if (rst || clear || word_we || flush) begin
      cnt <= 2'd0;
      for (int i = 0; i < 4; i++) lane[i] <= 8'h00;
    end else if (data_valid) begin
      cnt       <= cnt + 2'd1;
      lane[cnt] <= data;
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory loaded over a byte-serial port, fetched through a
// valid/ready handshake with a registered one-cycle read and PC fault flags.
//
//   state | meaning
//   RUN   | fetches accepted, load port closed
//   LOAD  | load bytes accepted and packed into words, fetch blocked
module imem_loadable
  import imem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_overflow,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [1:0]        inst_fault
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t state, state_n;
  logic enter_load, exit_load;
  logic ld_accept, ld_keep, fetch_accept;
  logic [ADDR_W-1:0] word_ptr;
  logic full;
  logic [31:0] pack_word;
  logic pack_we;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PC_W-1:0] pc_word;
  logic [1:0] fault_n;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ld_ready    = 1'b0;
    fetch_ready = 1'b0;
    enter_load  = 1'b0;
    exit_load   = 1'b0;
    case (state)
      RUN: begin
        fetch_ready = 1'b1;
        if (load_en) begin
          state_n    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (!load_en) begin
          state_n   = RUN;
          exit_load = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign ld_accept    = ld_valid && ld_ready;
  assign ld_keep      = ld_accept && !full;
  assign fetch_accept = fetch_valid && fetch_ready;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (enter_load),
    .data_valid (ld_keep),
    .data       (ld_byte),
    .flush      (exit_load),
    .word       (pack_word),
    .word_we    (pack_we)
  );

  // Once the last word is written the pointer saturates; later bytes only flag overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_ptr    <= '0;
      full        <= 1'b0;
      ld_overflow <= 1'b0;
      ld_done     <= 1'b0;
    end else begin
      ld_done <= exit_load;
      if (enter_load) begin
        word_ptr    <= '0;
        full        <= 1'b0;
        ld_overflow <= 1'b0;
      end else begin
        if (ld_accept && full) ld_overflow <= 1'b1;
        if (pack_we && !full) begin
          if (&word_ptr) full <= 1'b1;
          else           word_ptr <= word_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && pack_we && !full) mem[word_ptr] <= DATA_W'(pack_word);
  end

  assign pc_word                 = fetch_pc >> 2;
  assign fault_n[FAULT_MISALIGN] = |fetch_pc[1:0];
  assign fault_n[FAULT_RANGE]    = pc_word >= PC_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst       <= DATA_W'(NOP_INST);
      inst_fault <= 2'b00;
    end else begin
      inst_valid <= fetch_accept;
      if (fetch_accept) begin
        inst_fault <= fault_n;
        inst       <= (|fault_n) ? DATA_W'(NOP_INST) : mem[fetch_pc[ADDR_W+1:2]];
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Drives a 64-word and a 4-word instance with identical stimulus and checks
// both against a word-level model of load sessions and fetch results.
module tb_imem_loadable;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_en, ld_valid, fetch_valid;
  logic [7:0]  ld_byte;
  logic [31:0] fetch_pc;

  logic        ld_ready_w, ld_done_w, ld_overflow_w, fetch_ready_w, inst_valid_w;
  logic [31:0] inst_w;
  logic [1:0]  inst_fault_w;
  logic        ld_ready_n, ld_done_n, ld_overflow_n, fetch_ready_n, inst_valid_n;
  logic [31:0] inst_n;
  logic [1:0]  inst_fault_n;

  imem_loadable #(.ADDR_W(6), .DATA_W(32), .PC_W(32)) dut_w (
    .clk(clk), .rst(rst), .load_en(load_en), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready_w), .ld_done(ld_done_w), .ld_overflow(ld_overflow_w),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready_w),
    .inst_valid(inst_valid_w), .inst(inst_w), .inst_fault(inst_fault_w)
  );

  imem_loadable #(.ADDR_W(2), .DATA_W(32), .PC_W(32)) dut_n (
    .clk(clk), .rst(rst), .load_en(load_en), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready_n), .ld_done(ld_done_n), .ld_overflow(ld_overflow_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready_n),
    .inst_valid(inst_valid_n), .inst(inst_n), .inst_fault(inst_fault_n)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory image per instance, current load session as a byte list.
  int          dep [2] = '{64, 4};
  logic [31:0] mref [2][64];
  byte unsigned lbytes[$];
  bit          m_load = 0;
  bit          exp_done = 0;
  bit          exp_ovf [2] = '{0, 0};
  exp_t        q0[$], q1[$];
  byte unsigned sq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, expv, $time);
    end
  endtask

  function automatic exp_t expect_of(input int d, input logic [31:0] pc);
    exp_t e;
    logic [31:0] wi;
    wi = pc >> 2;
    e.fault[0] = (pc[1:0] != 2'b00);
    e.fault[1] = (wi >= 32'(dep[d]));
    e.inst     = (e.fault != 2'b00) ? NOP : mref[d][wi[5:0]];
    return e;
  endfunction

  // Words built from the session's bytes; full_only drops a trailing partial word.
  task automatic commit(input bit full_only);
    int n, nw;
    logic [31:0] word;
    n  = lbytes.size();
    nw = full_only ? n / 4 : (n + 3) / 4;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < nw; w++)
        if (w < dep[d]) begin
          word = 32'h0;
          for (int b = 0; b < 4; b++)
            if (4 * w + b < n) word[8*b +: 8] = lbytes[4*w+b];
          mref[d][w] = word;
        end
  endtask

  // One clock: model the edge from current inputs, then check flags just after it.
  task automatic step();
    bit   acc;
    exp_t e0, e1;
    acc = 0;
    if (rst) begin
      if (m_load) commit(1);
      m_load = 0; exp_done = 0; exp_ovf = '{0, 0};
      lbytes.delete();
    end else if (!m_load) begin
      exp_done = 0;
      if (fetch_valid) begin
        acc = 1;
        e0  = expect_of(0, fetch_pc);
        e1  = expect_of(1, fetch_pc);
      end
      if (load_en) begin
        m_load = 1; exp_ovf = '{0, 0};
        lbytes.delete();
      end
    end else begin
      if (ld_valid) lbytes.push_back(ld_byte);
      for (int d = 0; d < 2; d++)
        if (lbytes.size() > 4 * dep[d]) exp_ovf[d] = 1;
      exp_done = 0;
      if (!load_en) begin
        commit(0);
        m_load = 0; exp_done = 1;
      end
    end
    @(posedge clk);
    if (acc) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    #1;
    chk("ld_done_w", 32'(ld_done_w), 32'(exp_done));
    chk("ld_done_n", 32'(ld_done_n), 32'(exp_done));
    chk("ld_overflow_w", 32'(ld_overflow_w), 32'(exp_ovf[0]));
    chk("ld_overflow_n", 32'(ld_overflow_n), 32'(exp_ovf[1]));
    chk("fetch_ready_w", 32'(fetch_ready_w), 32'(!m_load));
    chk("ld_ready_n", 32'(ld_ready_n), 32'(m_load));
  endtask

  task automatic check_resp(input int d, input logic [31:0] gi, input logic [1:0] gf);
    exp_t e;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      total++; bad++;
      $display("FAIL unexpected_inst_valid dut%0d: got inst=%h with no pending fetch", d, gi);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk(d == 0 ? "inst_w" : "inst_n", gi, e.inst);
      chk(d == 0 ? "fault_w" : "fault_n", 32'(gf), 32'(e.fault));
    end
  endtask

  always @(negedge clk) begin
    if (inst_valid_w) check_resp(0, inst_w, inst_fault_w);
    else if (q0.size() != 0) chk("missing_resp_w", 32'(q0.size()), 32'd0);
    if (inst_valid_n) check_resp(1, inst_n, inst_fault_n);
    else if (q1.size() != 0) chk("missing_resp_n", 32'(q1.size()), 32'd0);
    if (inst_valid_w || inst_valid_n) begin
      chk("latency_w", 32'(q0.size()), 32'd0);
      chk("latency_n", 32'(q1.size()), 32'd0);
      q0.delete(); q1.delete();
    end
  end

  task automatic fetch(input logic [31:0] pc);
    fetch_valid = 1; fetch_pc = pc;
    step();
    fetch_valid = 0;
  endtask

  task automatic open_load();
    load_en = 1;
    step();
  endtask

  // Sends sq; optionally presents the final byte in the exit cycle itself.
  task automatic send_bytes(input bit gaps, input bit last_on_exit);
    int n;
    n = sq.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        ld_valid = 0;
        step();
      end
      ld_valid = 1; ld_byte = sq[i];
      if (last_on_exit && i == n - 1) load_en = 0;
      step();
    end
    ld_valid = 0;
    sq.delete();
  endtask

  task automatic close_load();
    load_en = 0; ld_valid = 0;
    step();
  endtask

  task automatic random_fetch(input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: pc = 32'($urandom_range(0, 63)) << 2;
        3:       pc = 32'($urandom_range(0, 3)) << 2;
        4:       pc = $urandom & 32'h1FF;
        default: pc = $urandom;
      endcase
      fetch_valid = ($urandom_range(0, 4) != 0); fetch_pc = pc;
      step();
    end
    fetch_valid = 0;
  endtask

  initial begin
    rst = 1; load_en = 0; ld_valid = 0; ld_byte = 8'h00; fetch_valid = 0; fetch_pc = 32'h0;
    step(); step();
    chk("reset_inst_w", inst_w, NOP);
    chk("reset_inst_n", inst_n, NOP);
    chk("reset_valid_w", 32'(inst_valid_w), 32'd0);
    chk("reset_fault_w", 32'(inst_fault_w), 32'd0);
    chk("reset_ld_ready_w", 32'(ld_ready_w), 32'd0);
    rst = 0;
    step();

    // Fill every word of both instances with random bytes (narrow one overflows).
    for (int i = 0; i < 256; i++) sq.push_back(byte'($urandom));
    open_load(); send_bytes(1, 0); close_load();
    step();
    random_fetch(40);

    // Two-instruction program.
    sq = '{8'h13, 8'h03, 8'hA0, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00};
    open_load(); send_bytes(0, 0); close_load();
    fetch(32'h0); fetch(32'h4);
    fetch(32'h6); fetch(32'h100); fetch(32'h102); fetch(32'h10);

    // Partial trailing word padded with zeros.
    sq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    open_load(); send_bytes(0, 0); close_load();
    fetch(32'h4); fetch(32'h0);

    // Reset after word 0 and half of word 1: word 1 keeps its old value.
    sq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    open_load(); send_bytes(0, 0);
    rst = 1; load_en = 0;
    step();
    rst = 0;
    step();
    fetch(32'h0); fetch(32'h4);

    // Back-to-back fetches with load_en (and a byte) arriving on the third.
    fetch_valid = 1; fetch_pc = 32'h0; step();
    fetch_pc = 32'h4; step();
    fetch_pc = 32'h8; load_en = 1; ld_valid = 1; ld_byte = 8'hEE; step();
    fetch_valid = 0; ld_valid = 0;
    step();
    sq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(0, 1);
    step();
    fetch(32'h0); fetch(32'h4); fetch(32'h8);

    // Random load sessions, with and without overflow on the narrow instance.
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(0, 22);
      for (int i = 0; i < len; i++) sq.push_back(byte'($urandom));
      open_load();
      send_bytes(1, $urandom_range(0, 1) == 1);
      if (load_en) close_load();
      step();
      random_fetch(12);
    end

    step(); step();
    chk("drain_w", 32'(q0.size()), 32'd0);
    chk("drain_n", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
